// File: rtl/cfg_spi_master.sv
// SPI master for single-register config accesses: one 16-bit frame {write, addr, data}
// per request, optional tail clocks, read-back byte returned as a one-cycle response.
`timescale 1ns/1ps
module cfg_spi_master #(
   parameter int CLK_DIV   = 4,
   parameter int SETUP_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int GAP_CYC   = 4,
   parameter int TAIL_CLKS = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       cs,
   output logic       spi_clk,
   output logic       pico,
   input  logic       poci
);

   localparam int NB = 16 + TAIL_CLKS;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [4:0]    BIT_LAST   = 5'(NB - 1);
   localparam logic [7:0]    SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0]    HOLD_LAST  = 8'(HOLD_CYC - 1);
   localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [DW-1:0] div_cnt;
   logic [4:0]    bit_cnt;
   logic [15:0]   shreg;
   logic [7:0]    rd_sh;
   logic          wr_flag;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         div_cnt   <= '0;
         bit_cnt   <= 5'd0;
         shreg     <= 16'h0000;
         rd_sh     <= 8'h00;
         wr_flag   <= 1'b0;
         cs        <= 1'b0;
         spi_clk   <= 1'b0;
         pico      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state   <= SETUP;
                  cs      <= 1'b1;
                  shreg   <= {req_write, req_addr, (req_write ? req_wdata : 8'h00)};
                  pico    <= req_write;
                  wr_flag <= req_write;
                  rd_sh   <= 8'h00;
                  cnt     <= 8'd0;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state   <= SHIFT;
                  cnt     <= 8'd0;
                  div_cnt <= '0;
                  bit_cnt <= 5'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!spi_clk) begin
                     spi_clk <= 1'b1;
                     // Only the data-phase bits (8..15) carry read-back from the slave.
                     if (bit_cnt[4:3] == 2'b01) rd_sh <= {rd_sh[6:0], poci};
                  end else begin
                     spi_clk <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= HOLD;
                        pico  <= 1'b0;
                        cnt   <= 8'd0;
                     end else begin
                        // Zeros shift in behind the frame, so tail bits go out as 0.
                        bit_cnt <= bit_cnt + 5'd1;
                        shreg   <= {shreg[14:0], 1'b0};
                        pico    <= shreg[14];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state     <= GAP;
                  cs        <= 1'b0;
                  cnt       <= 8'd0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= wr_flag ? 8'h00 : rd_sh;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) state <= IDLE;
               else                 cnt   <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_spi_master.sv
// Directed bench for cfg_spi_master: default instance plus a CLK_DIV=2/TAIL_CLKS=0 instance,
// with a bus monitor and a poci slave model that follows the selected instance.
`timescale 1ns/1ps
module tb_cfg_spi_master;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       sel = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [6:0] req_addr = 7'd0;
   logic [7:0] req_wdata = 8'h00;
   logic [7:0] slave_byte = 8'h00;
   logic       poci;

   logic       rv1, rdy1, rspv1, busy1, cs1, sclk1, pico1;
   logic [7:0] rdata1;
   logic       rv2, rdy2, rspv2, busy2, cs2, sclk2, pico2;
   logic [7:0] rdata2;

   logic       m_cs, m_sclk, m_pico, m_rsp_valid, m_ready, m_busy;
   logic [7:0] m_rdata;

   int          checks = 0;
   int          errors = 0;
   int          rises = 0;
   int          frame_rises = 0;
   int          cs_cnt = 0;
   int          rsp_cnt = 0;
   int          viol = 0;
   logic [31:0] pico_bits = 32'h0;
   logic        prev_cs = 1'b0;
   logic        prev_sclk = 1'b0;

   always #5 clk = ~clk;

   assign rv1 = req_valid & ~sel;
   assign rv2 = req_valid & sel;

   cfg_spi_master dut (
      .clk(clk), .rstn(rstn), .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv1), .rsp_rdata(rdata1),
      .busy(busy1), .cs(cs1), .spi_clk(sclk1), .pico(pico1), .poci(poci)
   );

   cfg_spi_master #(.CLK_DIV(2), .TAIL_CLKS(0)) dut2 (
      .clk(clk), .rstn(rstn), .req_valid(rv2), .req_ready(rdy2), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv2), .rsp_rdata(rdata2),
      .busy(busy2), .cs(cs2), .spi_clk(sclk2), .pico(pico2), .poci(poci)
   );

   assign m_cs        = sel ? cs2   : cs1;
   assign m_sclk      = sel ? sclk2 : sclk1;
   assign m_pico      = sel ? pico2 : pico1;
   assign m_rsp_valid = sel ? rspv2 : rspv1;
   assign m_ready     = sel ? rdy2  : rdy1;
   assign m_busy      = sel ? busy2 : busy1;
   assign m_rdata     = sel ? rdata2 : rdata1;

   // Slave drives the read byte MSB first on frame bits 8..15, changing only between rises.
   assign poci = (frame_rises >= 8 && frame_rises < 16) ? slave_byte[3'(15 - frame_rises)] : 1'b0;

   always @(negedge clk) begin
      prev_cs   <= m_cs;
      prev_sclk <= m_sclk;
      if (m_cs) cs_cnt <= cs_cnt + 1;
      if (m_rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (!m_cs) frame_rises <= 0;
      else if (m_sclk && !prev_sclk) frame_rises <= frame_rises + 1;
      if (m_sclk && !prev_sclk) begin
         rises     <= rises + 1;
         pico_bits <= {pico_bits[30:0], m_pico};
      end
      if (((m_sclk != prev_sclk) && !m_cs && !prev_cs) || ((m_cs != prev_cs) && (m_sclk != prev_sclk)))
         viol <= viol + 1;
   end

   // Accept happens at the posedge following the caller's negedge; returns once ready is back.
   task automatic wait_frame(input logic [31:0] exp_bits, input int nb, input int exp_cs,
                             input int exp_rsp, input int exp_rdy, input logic [7:0] exp_rdata);
      int r0, c0, q0, n, rsp_n, rsp_w, rdy_n;
      logic [7:0]  cap;
      logic [31:0] mask;
      r0 = rises; c0 = cs_cnt; q0 = rsp_cnt;
      rsp_n = 0; rsp_w = 0; rdy_n = 0; cap = 8'hxx;
      mask = (32'd1 << nb) - 32'd1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      checks++;
      if ({m_ready, m_busy, m_cs} !== 3'b011) begin
         errors++;
         $display("FAIL accept_state: ready/busy/cs got %b expected 011", {m_ready, m_busy, m_cs});
      end
      while (n < 400 && rdy_n == 0) begin
         if (m_rsp_valid) begin
            rsp_w++;
            if (rsp_n == 0) begin rsp_n = n; cap = m_rdata; end
         end
         if (m_ready) rdy_n = n;
         else begin @(negedge clk); n++; end
      end
      checks++;
      if (rsp_n !== exp_rsp) begin errors++; $display("FAIL rsp_time: got %0d expected %0d", rsp_n, exp_rsp); end
      checks++;
      if (rsp_w !== 1) begin errors++; $display("FAIL rsp_width: got %0d expected 1", rsp_w); end
      checks++;
      if (rdy_n !== exp_rdy) begin errors++; $display("FAIL ready_time: got %0d expected %0d", rdy_n, exp_rdy); end
      checks++;
      if (cap !== exp_rdata) begin errors++; $display("FAIL rsp_rdata: got %h expected %h", cap, exp_rdata); end
      checks++;
      if (rises - r0 !== nb) begin errors++; $display("FAIL rises: got %0d expected %0d", rises - r0, nb); end
      checks++;
      if (cs_cnt - c0 !== exp_cs) begin errors++; $display("FAIL cs_high: got %0d expected %0d", cs_cnt - c0, exp_cs); end
      checks++;
      if ((pico_bits & mask) !== exp_bits) begin
         errors++; $display("FAIL pico_bits: got %h expected %h", pico_bits & mask, exp_bits);
      end
      checks++;
      if (rsp_cnt - q0 !== 1) begin errors++; $display("FAIL rsp_count: got %0d expected 1", rsp_cnt - q0); end
   endtask

   task automatic drive_req(input logic wr, input logic [6:0] addr, input logic [7:0] wd);
      @(negedge clk);
      req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      checks++;
      if (m_ready !== 1'b1) begin errors++; $display("FAIL ready_before: got %b expected 1", m_ready); end
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({cs1, sclk1, pico1, rdy1, busy1, rspv1} !== 6'b000100) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000100", {cs1, sclk1, pico1, rdy1, busy1, rspv1});
      end
      checks++;
      if (rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata1); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_write;
      slave_byte = 8'hFF;
      drive_req(1'b1, 7'd2, 8'hA5);
      wait_frame(32'h1054A, 17, 140, 141, 145, 8'h00);
   endtask

   task automatic test_read;
      slave_byte = 8'h3F;
      drive_req(1'b0, 7'd1, 8'hFF);
      wait_frame(32'h00200, 17, 140, 141, 145, 8'h3F);
   endtask

   task automatic test_back_to_back;
      int t[3];
      int acc, n, q0, r0;
      logic prev_rdy;
      slave_byte = 8'h00;
      drive_req(1'b1, 7'd13, 8'h5A);
      prev_rdy = m_ready; q0 = rsp_cnt; r0 = rises;
      acc = 0; n = 0;
      while (acc < 3 && n < 600) begin
         @(negedge clk); n++;
         if (prev_rdy && !m_ready) begin t[acc] = n; acc++; end
         prev_rdy = m_ready;
      end
      req_valid = 1'b0;
      while (!m_ready && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (acc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
      if (acc == 3) begin
         checks++;
         if (t[1] - t[0] !== 145) begin errors++; $display("FAIL b2b_spacing1: got %0d expected 145", t[1] - t[0]); end
         checks++;
         if (t[2] - t[1] !== 145) begin errors++; $display("FAIL b2b_spacing2: got %0d expected 145", t[2] - t[1]); end
      end
      @(negedge clk);
      checks++;
      if (rsp_cnt - q0 !== 3) begin errors++; $display("FAIL b2b_rsps: got %0d expected 3", rsp_cnt - q0); end
      checks++;
      if (rises - r0 !== 51) begin errors++; $display("FAIL b2b_rises: got %0d expected 51", rises - r0); end
   endtask

   task automatic test_reset_mid_frame;
      int q0;
      drive_req(1'b1, 7'd0, 8'h77);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (59) @(negedge clk);
      q0 = rsp_cnt;
      rstn = 1'b0;
      #1;
      checks++;
      if ({cs1, sclk1, pico1, rdy1, busy1, rspv1} !== 6'b000100) begin
         errors++; $display("FAIL midreset_ctrl: got %b expected 000100", {cs1, sclk1, pico1, rdy1, busy1, rspv1});
      end
      checks++;
      if (rdata1 !== 8'h00) begin errors++; $display("FAIL midreset_rdata: got %h expected 00", rdata1); end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (150) @(negedge clk);
      checks++;
      if (rsp_cnt !== q0) begin errors++; $display("FAIL aborted_rsp: got %0d expected %0d", rsp_cnt, q0); end
      test_read();
   endtask

   task automatic test_reset_held;
      @(negedge clk);
      rstn = 1'b0;
      req_write = 1'b1; req_addr = 7'd2; req_wdata = 8'hA5; req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({rdy1, cs1} !== 2'b10) begin errors++; $display("FAIL held_in_reset: got %b expected 10", {rdy1, cs1}); end
      rstn = 1'b1;
      wait_frame(32'h1054A, 17, 140, 141, 145, 8'h00);
   endtask

   task automatic test_clkdiv2;
      sel = 1'b1;
      slave_byte = 8'hC6;
      drive_req(1'b0, 7'd1, 8'h00);
      wait_frame(32'h0100, 16, 68, 69, 73, 8'hC6);
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_read();
      test_reset_mid_frame();
      test_reset_held();
      test_clkdiv2();
      @(negedge clk);
      checks++;
      if (viol !== 0) begin errors++; $display("FAIL bus_rules: got %0d expected 0", viol); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
